stopwatch_ctrl: RTL and testbench

- Run-control sequencer for the DE10-Lite stopwatch counter chain: start/stop, lap and clear.
- Debounces two push buttons (KEY, active-low) and synchronises the clear switch.
- Runs a 5-state FSM and emits one 0.1 s tick-enable pulse for the digit counters, plus a counter clear and a display freeze.
- Sits between board I/O and the counter/decoder datapath on the 50 MHz clock.

---
 rtl/stopwatch_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
//
// Run-control sequencer for the stopwatch counter chain. Synchronises and
// debounces the start/stop and lap buttons, synchronises the clear switch,
// runs the IDLE/RUN/PAUSE/LAP/FULL state machine and produces the 0.1 s tick
// enable, the counter clear and the display freeze for the digit datapath.
//
// Optional feature macro: STOPWATCH_LAP_EN
//   defined   : LAP state present, display_freeze driven in LAP.
//   undefined : no LAP state, lap in RUN ignored, display_freeze stays 0.
//
// Parameters
//   DIV        clk cycles per 0.1 s tick (>= 2)
//   DB_CYCLES  debounce stability window in clk cycles (>= 1)
//
// Ports
//   clk             system clock
//   reset           synchronous, active-high reset
//   btn_start_n     raw start/stop button, active-low, asynchronous
//   btn_lap_n       raw lap/reset button, active-low, asynchronous
//   sw_clear        raw clear switch, active-high level, asynchronous
//   at_max          counters currently show their maximum value
//   tick_01s        one-cycle count enable for the 0.1 s digit
//   counter_clr     synchronous clear for all digit counters
//   display_freeze  hold the decoder inputs (lap display)
//   state           FSM state: IDLE=0, RUN=1, PAUSE=2, LAP=3, FULL=4
//   running         high in RUN or LAP
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int unsigned DIV       = 5000000,
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start_n,
    input  logic       btn_lap_n,
    input  logic       sw_clear,
    input  logic       at_max,
    output logic       tick_01s,
    output logic       counter_clr,
    output logic       display_freeze,
    output logic [2:0] state,
    output logic       running
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRun   = 3'd1,
        StPause = 3'd2,
        StLap   = 3'd3,
        StFull  = 3'd4
    } state_e;

    localparam int unsigned PreW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned DbW  = $clog2(DB_CYCLES + 1);
    localparam logic [PreW-1:0] PreLast = PreW'(DIV - 1);
    localparam logic [DbW-1:0]  DbLast  = DbW'(DB_CYCLES - 1);

    // Bit 0 = start button, bit 1 = lap button, bit 2 = clear switch.
    logic [2:0] sync1_q, sync2_q;

    logic [DbW-1:0] db_cnt_q [2];
    logic [DbW-1:0] db_cnt_d [2];
    logic [1:0]     db_lvl_q, db_lvl_d;
    logic [1:0]     press_q, press_d;

    logic [PreW-1:0] pre_q, pre_d;
    state_e          state_q, state_d;

    logic tick_q, tick_d;
    logic clr_q, clr_d;
    logic freeze_q, freeze_d;
    logic running_q, running_d;

    logic clr_sync;
    logic start_ev;
    logic lap_ev;
    logic wrap;

    assign clr_sync = sync2_q[2];
    assign start_ev = press_q[0] & ~clr_sync;
    // Simultaneous start and lap: lap is dropped.
    assign lap_ev   = press_q[1] & ~clr_sync & ~press_q[0];
    assign wrap     = (pre_q == PreLast);

    // ---------------------------------------------------------------------
    // Debounce: restart whenever the synchronised level matches the
    // debounced one; adopt the new level after DB_CYCLES stable cycles.
    // ---------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            db_lvl_d[i] = db_lvl_q[i];
            if (sync2_q[i] == db_lvl_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DbLast) begin
                db_lvl_d[i] = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
            end
        end
        // Press = falling edge of the debounced level; dropped under clear.
        press_d = db_lvl_q & ~db_lvl_d & {2{~clr_sync}};
    end

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start_ev) state_d = StRun;
            end
            StRun: begin
                if (start_ev)             state_d = StPause;
                else if (wrap && at_max)  state_d = StFull;
`ifdef STOPWATCH_LAP_EN
                else if (lap_ev)          state_d = StLap;
`endif
            end
`ifdef STOPWATCH_LAP_EN
            StLap: begin
                if (start_ev)             state_d = StPause;
                else if (wrap && at_max)  state_d = StFull;
                else if (lap_ev)          state_d = StRun;
            end
`endif
            StPause: begin
                if (start_ev)    state_d = StRun;
                else if (lap_ev) state_d = StIdle;
            end
            StFull: begin
                if (lap_ev) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (clr_sync) state_d = StIdle;
    end

    // ---------------------------------------------------------------------
    // FSM: outputs and prescaler next values (all registered)
    // ---------------------------------------------------------------------
    always_comb begin
        pre_d  = pre_q;
        tick_d = 1'b0;
        case (state_q)
            StRun, StLap: begin
                if (wrap) begin
                    pre_d  = '0;
                    // Suppress the tick at max so the counters never roll over.
                    tick_d = ~at_max;
                end else begin
                    pre_d = pre_q + PreW'(1);
                end
            end
            StPause: begin
                if (lap_ev) pre_d = '0;
            end
            default: pre_d = '0;
        endcase

        clr_d = lap_ev & ((state_q == StPause) | (state_q == StFull));
        if (clr_sync) begin
            pre_d  = '0;
            tick_d = 1'b0;
            clr_d  = 1'b1;
        end

`ifdef STOPWATCH_LAP_EN
        freeze_d = (state_d == StLap);
`else
        freeze_d = 1'b0;
`endif
        running_d = (state_d == StRun) | (state_d == StLap);
    end

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 3'b011;
            sync2_q     <= 3'b011;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
            db_lvl_q    <= 2'b11;
            press_q     <= 2'b00;
            pre_q       <= '0;
            tick_q      <= 1'b0;
            clr_q       <= 1'b1;
            freeze_q    <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            sync1_q     <= {sw_clear, btn_lap_n, btn_start_n};
            sync2_q     <= sync1_q;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
            db_lvl_q    <= db_lvl_d;
            press_q     <= press_d;
            pre_q       <= pre_d;
            tick_q      <= tick_d;
            clr_q       <= clr_d;
            freeze_q    <= freeze_d;
            running_q   <= running_d;
        end
    end

    assign tick_01s       = tick_q;
    assign counter_clr    = clr_q;
    assign display_freeze = freeze_q;
    assign state          = state_q;
    assign running        = running_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_start_n;
    logic       btn_lap_n;
    logic       sw_clear;
    logic       at_max;
    logic       tick_01s;
    logic       counter_clr;
    logic       display_freeze;
    logic [2:0] state;
    logic       running;

    int checks   = 0;
    int failures = 0;

    stopwatch_ctrl #(
        .DIV       (10),
        .DB_CYCLES (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_start_n    (btn_start_n),
        .btn_lap_n      (btn_lap_n),
        .sw_clear       (sw_clear),
        .at_max         (at_max),
        .tick_01s       (tick_01s),
        .counter_clr    (counter_clr),
        .display_freeze (display_freeze),
        .state          (state),
        .running        (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start_n;
        logic       lap_n;
        logic       clr;
        logic       at_max;
        int         cyc;
        logic [2:0] st;
        logic       tick;
        logic       clr_o;
        logic       frz;
        logic       run;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic count_ticks(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (tick_01s === 1'b1) cnt++;
        end
    endtask

    // Hold the button(s) low for 10 cycles, check outputs 7 edges after the
    // press starts, then release and let the debouncer settle.
    // Returns 10 edges after the state change.
    task automatic press(input logic s, input logic l, input logic [2:0] exp_st,
                         input logic exp_clr, input logic exp_frz, input string name);
        btn_start_n = ~s;
        btn_lap_n   = ~l;
        step(7);
        chk({name, "_state"}, 32'(state), 32'(exp_st));
        chk({name, "_clr"}, 32'(counter_clr), 32'(exp_clr));
        chk({name, "_freeze"}, 32'(display_freeze), 32'(exp_frz));
        step(1);
        chk({name, "_clr_next"}, 32'(counter_clr), 32'd0);
        step(2);
        btn_start_n = 1'b1;
        btn_lap_n   = 1'b1;
        step(7);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        //            st  lp cl mx cyc st  tk clr fz run
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 7,  3'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3,  3'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 7,  3'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 6,  3'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1,  3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1,  3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2,  3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 7,  3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7,  3'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3,  3'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 7,  3'd1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 2,  3'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1,  3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 5,  3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 10, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 7,  3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 2,  3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 1,  3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 7,  3'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 3,  3'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[20] = '{1'b1, 1'b1, 1'b0, 1'b0, 7,  3'd1, 1'b1, 1'b0, 1'b0, 1'b1};

        reset       = 1'b1;
        btn_start_n = 1'b1;
        btn_lap_n   = 1'b1;
        sw_clear    = 1'b0;
        at_max      = 1'b0;

        // Reset values
        step(2);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_clr", 32'(counter_clr), 32'd1);
        chk("rst_tick", 32'(tick_01s), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_freeze", 32'(display_freeze), 32'd0);
        reset = 1'b0;
        step(1);
        chk("post_rst_clr", 32'(counter_clr), 32'd0);
        chk("post_rst_state", 32'(state), 32'd0);

        // Bounce: 3 low, 1 high, 3 low -> never 4 stable cycles
        btn_start_n = 1'b0; step(3);
        btn_start_n = 1'b1; step(1);
        btn_start_n = 1'b0; step(3);
        btn_start_n = 1'b1; step(10);
        chk("bounce_state", 32'(state), 32'd0);

        // Start from IDLE: RUN at edge 7, ticks at +10 and +20
        btn_start_n = 1'b0;
        step(6);
        chk("start_wait_state", 32'(state), 32'd0);
        step(1);
        chk("start_state", 32'(state), 32'd1);
        chk("start_running", 32'(running), 32'd1);
        step(3);
        btn_start_n = 1'b1;
        step(6);
        chk("tick1_early", 32'(tick_01s), 32'd0);
        step(1);
        chk("tick1", 32'(tick_01s), 32'd1);
        step(1);
        chk("tick1_width", 32'(tick_01s), 32'd0);
        step(8);
        chk("tick2_early", 32'(tick_01s), 32'd0);
        step(1);
        chk("tick2", 32'(tick_01s), 32'd1);

        // Pause landing with prescaler=6 (transition 16 edges after a wrap)
        step(9);
        btn_start_n = 1'b0;
        step(7);
        chk("pause_state", 32'(state), 32'd2);
        chk("pause_running", 32'(running), 32'd0);
        step(3);
        btn_start_n = 1'b1;
        count_ticks(7, n);
        chk("pause_no_ticks", 32'(n), 32'd0);

        // Resume: prescaler held at 6 -> tick 4 edges after re-entering RUN
        btn_start_n = 1'b0;
        step(7);
        chk("resume_state", 32'(state), 32'd1);
        step(3);
        btn_start_n = 1'b1;
        chk("resume_tick_early", 32'(tick_01s), 32'd0);
        step(1);
        chk("resume_tick", 32'(tick_01s), 32'd1);
        step(6);

`ifdef STOPWATCH_LAP_EN
        press(1'b0, 1'b1, 3'd3, 1'b0, 1'b1, "lap_enter");
        count_ticks(20, n);
        chk("lap_ticks", 32'(n), 32'd2);
        chk("lap_freeze_held", 32'(display_freeze), 32'd1);
        chk("lap_running", 32'(running), 32'd1);
        press(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, "lap_exit");
`else
        press(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, "lap_ignored");
`endif
        count_ticks(20, n);
        chk("run_ticks", 32'(n), 32'd2);

        // Start and lap together -> PAUSE only
        press(1'b1, 1'b1, 3'd2, 1'b0, 1'b0, "both");
        // Lap from PAUSE -> IDLE with one-cycle clear
        press(1'b0, 1'b1, 3'd0, 1'b1, 1'b0, "pause_lap");

        // at_max: RUN wraps into FULL with the tick suppressed
        at_max = 1'b1;
        press(1'b1, 1'b0, 3'd1, 1'b0, 1'b0, "full_start");
        chk("full_state", 32'(state), 32'd4);
        chk("full_no_tick", 32'(tick_01s), 32'd0);
        chk("full_running", 32'(running), 32'd0);

        // Table: FULL start/lap handling, then clear switch scenarios
        for (int i = 0; i < NVEC; i++) begin
            btn_start_n = vecs[i].start_n;
            btn_lap_n   = vecs[i].lap_n;
            sw_clear    = vecs[i].clr;
            at_max      = vecs[i].at_max;
            step(vecs[i].cyc);
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("vec%0d_tick", i), 32'(tick_01s), 32'(vecs[i].tick));
            chk($sformatf("vec%0d_clr", i), 32'(counter_clr), 32'(vecs[i].clr_o));
            chk($sformatf("vec%0d_freeze", i), 32'(display_freeze), 32'(vecs[i].frz));
            chk($sformatf("vec%0d_running", i), 32'(running), 32'(vecs[i].run));
        end

        // Reset landing on a prescaler wrap: no tick, reset values
        step(9);
        reset = 1'b1;
        step(1);
        chk("midrst_tick", 32'(tick_01s), 32'd0);
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_clr", 32'(counter_clr), 32'd1);
        chk("midrst_running", 32'(running), 32'd0);
        reset = 1'b0;
        step(1);
        chk("midrst_clr_after", 32'(counter_clr), 32'd0);
        chk("midrst_state_after", 32'(state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Tick and clear must never coincide.
    always @(negedge clk) begin
        if (!reset && tick_01s && counter_clr) begin
            failures++;
            $display("FAIL tick_clr_overlap: got tick=1 clr=1 expected not both");
        end
    end

endmodule
